// File: rtl/inst_mem_loader.sv
// inst_mem_loader: packs a valid/ready instruction stream into paired write beats for the instruction memory load port
module inst_mem_loader #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W = 32,
    parameter logic [INS_W-1:0] PAD_WORD = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [INS_ADDRESS-1:0] base_address,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INS_W-1:0]       in_data,
    input  logic                   in_last,
    output logic                   enable_load_ex_mem,
    output logic [INS_ADDRESS-1:0] InstExMemAddress,
    output logic [INS_W-1:0]       InstExMemData1,
    output logic [INS_W-1:0]       InstExMemData2,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   load_error
);
    typedef enum logic [2:0] {IDLE, WORD1, WORD2, WRITE, DONE, ERROR} state_t;
    state_t state, next;
    logic last_f;
    logic accept;
    logic at_top;
    logic can_start;
    assign accept = in_valid && in_ready;
    assign at_top = &InstExMemAddress;
    assign can_start = start && (state == IDLE || state == DONE || state == ERROR);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE, DONE, ERROR: next = start ? WORD1 : state;
            WORD1:             next = accept ? (in_last ? WRITE : WORD2) : WORD1;
            WORD2:             next = accept ? WRITE : WORD2;
            WRITE:             next = last_f ? DONE : (at_top ? ERROR : WORD1);
            default:           next = IDLE;
        endcase
    end
    // status outputs are registered copies of the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready           <= 1'b0;
            enable_load_ex_mem <= 1'b0;
            load_busy          <= 1'b0;
            load_done          <= 1'b0;
            load_error         <= 1'b0;
            InstExMemAddress   <= '0;
            InstExMemData1     <= '0;
            InstExMemData2     <= '0;
            last_f             <= 1'b0;
        end else begin
            in_ready           <= next == WORD1 || next == WORD2;
            enable_load_ex_mem <= next == WRITE;
            load_busy          <= next == WORD1 || next == WORD2 || next == WRITE;
            load_done          <= next == DONE;
            load_error         <= next == ERROR;
            if (can_start) begin
                InstExMemAddress <= base_address;
                last_f           <= 1'b0;
            end
            if (state == WORD1 && accept) begin
                InstExMemData1 <= in_data;
                if (in_last) begin
                    InstExMemData2 <= PAD_WORD;
                    last_f         <= 1'b1;
                end
            end
            if (state == WORD2 && accept) begin
                InstExMemData2 <= in_data;
                last_f         <= in_last;
            end
            if (state == WRITE && !last_f && !at_top) InstExMemAddress <= InstExMemAddress + 1'b1;
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: randomized sessions checked against a pair-list model of the expected write beats
module tb_inst_mem_loader;
    localparam logic [31:0] PAD = 32'h0000_0013;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [8:0] base_address = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [31:0] in_data = '0;
    logic in_last = 1'b0;
    logic enable_load_ex_mem;
    logic [8:0] InstExMemAddress;
    logic [31:0] InstExMemData1;
    logic [31:0] InstExMemData2;
    logic load_busy;
    logic load_done;
    logic load_error;
    int n_chk = 0;
    int n_fail = 0;
    logic [72:0] exp_q[$];
    logic en_prev = 1'b0;

    inst_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_address(base_address),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .enable_load_ex_mem(enable_load_ex_mem), .InstExMemAddress(InstExMemAddress),
        .InstExMemData1(InstExMemData1), .InstExMemData2(InstExMemData2),
        .load_busy(load_busy), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // every strobe must match the next expected (addr, data1, data2) beat and last one cycle
    always @(negedge clk) begin
        if (enable_load_ex_mem) begin
            check("strobe_width", en_prev, 0);
            check("write_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                check("write_beat", {InstExMemAddress, InstExMemData1, InstExMemData2}, exp_q.pop_front());
        end
        en_prev <= enable_load_ex_mem;
    end

    task automatic feed(input logic [31:0] d, input bit last);
        int t;
        bit acc;
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        t = 0;
        do begin
            acc = in_ready;
            @(negedge clk);
            t++;
        end while (!acc && load_busy && t < 200);
        in_valid = 1'b0;
        in_last = 1'b0;
        if (t >= 200) check("accept_timeout", t, 0);
    endtask

    task automatic session(input logic [8:0] b, input int n, input bit has_last, input bit noisy);
        logic [31:0] w[$];
        logic [8:0] a;
        bit ed;
        bit ee;
        int t;
        a = b;
        ed = 0;
        ee = 0;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        for (int i = 0; 2 * i < n; i++) begin
            exp_q.push_back({a, w[2*i], (2 * i + 1 < n) ? w[2*i+1] : PAD});
            if (has_last && 2 * i + 2 >= n) begin ed = 1; break; end
            if (a == 9'h1ff) begin ee = 1; break; end
            a++;
        end
        @(negedge clk);
        start = 1'b1;
        base_address = b;
        @(negedge clk);
        start = 1'b0;
        base_address = 9'($urandom);
        check("busy_after_start", load_busy, 1);
        check("done_cleared", load_done, 0);
        check("error_cleared", load_error, 0);
        for (int i = 0; i < n && load_busy; i++) begin
            if (noisy)
                repeat ($urandom_range(0, 3)) begin
                    if ($urandom_range(0, 1) == 1 && load_busy) begin
                        start = 1'b1;
                        base_address = 9'($urandom);
                    end
                    @(negedge clk);
                    start = 1'b0;
                end
            feed(w[i], has_last && i == n - 1);
        end
        t = 0;
        while (load_busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("session_end", load_busy, 0);
        check("load_done", load_done, ed);
        check("load_error", load_error, ee);
        check("in_ready_idle", in_ready, 0);
        check("writes_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outputs", {in_ready, enable_load_ex_mem, load_busy, load_done, load_error}, 0);
        check("rst_regs", {InstExMemAddress, InstExMemData1, InstExMemData2}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", in_ready, 0);
        session(9'd0, 4, 1, 0);
        session(9'd5, 3, 1, 0);
        session(9'd511, 4, 0, 0);
        session(9'd0, 4, 1, 1);
        // reset while holding one word of a pair
        @(negedge clk);
        start = 1'b1;
        base_address = 9'd3;
        @(negedge clk);
        start = 1'b0;
        feed(32'hDEAD_BEEF, 0);
        check("in_word2", in_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", {in_ready, enable_load_ex_mem, load_busy, load_done, load_error}, 0);
        check("arst_regs", {InstExMemAddress, InstExMemData1, InstExMemData2}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {in_ready, load_busy, InstExMemData1}, 0);
        session(9'd0, 4, 1, 1);
        session(9'd10, 5, 1, 1);
        session(9'd510, 4, 1, 1);
        session(9'd508, 12, 0, 1);
        repeat (8) session(9'($urandom_range(0, 500)), $urandom_range(1, 9), 1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
